// File: rtl/crypto_pkg.sv
// Shared types and helpers for the crypto nibble receive path.
package crypto_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [0:0] {
    ST_NOKEY = 1'b0,
    ST_KEYED = 1'b1
  } state_e;

  // cipher = plain ^ key, so the same operation recovers the plaintext.
  function automatic logic [NIB_W-1:0] nib_xor(input logic [NIB_W-1:0] c,
                                               input logic [NIB_W-1:0] k);
    return c ^ k;
  endfunction

endpackage

// File: rtl/crypto_nib_fifo.sv
// Small registered FIFO holding decrypted nibbles; synchronous active-low reset.
module crypto_nib_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/crypto_decrypt_stream.sv
// Receive side of the crypto nibble path: XOR-decrypts cipher nibbles into an output FIFO.
// Optional key rolling after each accepted nibble is enabled by defining CRYPTO_KEY_ROLL_EN.
module crypto_decrypt_stream
  import crypto_pkg::*;
#(
  parameter int unsigned NIB_W = crypto_pkg::NIB_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [NIB_W-1:0] key_in,
  input  logic             cin_valid,
  input  logic [NIB_W-1:0] cin_data,
  output logic             cin_ready,
  output logic             pout_valid,
  output logic [NIB_W-1:0] pout_data,
  input  logic             pout_ready,
  output logic             keyed,
  output logic [CNT_W-1:0] nib_count
);

  state_e           state_q, state_d;
  logic [NIB_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic pop;

  // key_load wins over a data transfer; a full FIFO blocks even if it pops this cycle.
  assign cin_ready  = (state_q == ST_KEYED) && !key_load && !fifo_full;
  assign accept     = cin_valid && cin_ready;
  assign pout_valid = !fifo_empty;
  assign pop        = pout_valid && pout_ready;
  assign keyed      = (state_q == ST_KEYED);
  assign nib_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (key_load) begin
      state_d = ST_KEYED;
      key_d   = key_in;
      cnt_d   = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
`ifdef CRYPTO_KEY_ROLL_EN
      key_d = {key_q[NIB_W-2:0], key_q[NIB_W-1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NOKEY;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  crypto_nib_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NIB_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (accept),
    .wdata_i (nib_xor(cin_data, key_q)),
    .pop_i   (pop),
    .rdata_o (pout_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_crypto_decrypt_stream.sv
// Randomized bench for crypto_decrypt_stream with a queue-based reference model.
module tb_crypto_decrypt_stream;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_load;
  logic [3:0] key_in;
  logic       cin_valid;
  logic [3:0] cin_data;
  logic       cin_ready;
  logic       pout_valid;
  logic [3:0] pout_data;
  logic       pout_ready;
  logic       keyed;
  logic [7:0] nib_count;

  always #5 clk = ~clk;

  crypto_decrypt_stream #(
    .NIB_W (4),
    .DEPTH (DEPTH),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .cin_valid  (cin_valid),
    .cin_data   (cin_data),
    .cin_ready  (cin_ready),
    .pout_valid (pout_valid),
    .pout_data  (pout_data),
    .pout_ready (pout_ready),
    .keyed      (keyed),
    .nib_count  (nib_count)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] m_q [$];
  logic [3:0] m_key;
  logic [7:0] m_cnt;
  logic       m_keyed;
  logic       last_ready;
  logic [3:0] roll_exp [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; checks outputs before the edge, then advances the model.
  task automatic step(input logic kl, input logic [3:0] ki, input logic cv,
                      input logic [3:0] cd, input logic pr, input logic rn = 1'b1);
    logic exp_ready;
    key_load   = kl;
    key_in     = ki;
    cin_valid  = cv;
    cin_data   = cd;
    pout_ready = pr;
    rst_n      = rn;
    @(negedge clk);
    exp_ready  = m_keyed && !kl && (m_q.size() < DEPTH);
    last_ready = cin_ready;
    chk("cin_ready", {31'd0, cin_ready}, {31'd0, exp_ready});
    chk("pout_valid", {31'd0, pout_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("pout_data", {28'd0, pout_data}, {28'd0, m_q[0]});
    chk("keyed", {31'd0, keyed}, {31'd0, m_keyed});
    chk("nib_count", {24'd0, nib_count}, {24'd0, m_cnt});
    if (!rn) begin
      m_q.delete();
      m_key   = '0;
      m_cnt   = '0;
      m_keyed = 1'b0;
    end else begin
      if (m_q.size() != 0 && pr) void'(m_q.pop_front());
      if (kl) begin
        m_key   = ki;
        m_cnt   = '0;
        m_keyed = 1'b1;
      end else if (exp_ready && cv) begin
        m_q.push_back(cd ^ m_key);
        m_cnt = m_cnt + 8'd1;
`ifdef CRYPTO_KEY_ROLL_EN
        m_key = {m_key[2:0], m_key[3]};
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef CRYPTO_KEY_ROLL_EN
    roll_exp[0] = 4'hA; roll_exp[1] = 4'h5; roll_exp[2] = 4'hA;
`else
    roll_exp[0] = 4'hA; roll_exp[1] = 4'hA; roll_exp[2] = 4'hA;
`endif
    m_key = '0; m_cnt = '0; m_keyed = 1'b0; last_ready = 1'b0;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0;
    cin_valid = 1'b0; cin_data = '0; pout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cin_ready", {31'd0, cin_ready}, 32'd0);
    chk("rst_pout_valid", {31'd0, pout_valid}, 32'd0);
    chk("rst_pout_data", {28'd0, pout_data}, 32'd0);
    chk("rst_keyed", {31'd0, keyed}, 32'd0);
    chk("rst_count", {24'd0, nib_count}, 32'd0);

    // Keyless: valid data before any key is refused.
    step(1'b0, 4'h0, 1'b1, 4'h5, 1'b1);
    chk("keyless_ready", {31'd0, last_ready}, 32'd0);
    chk("keyless_valid", {31'd0, pout_valid}, 32'd0);
    chk("keyless_keyed", {31'd0, keyed}, 32'd0);

    // Basic decrypt.
    step(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 4'h6, 1'b1);
    chk("basic_data", {28'd0, pout_data}, 32'hC);
    chk("basic_count", {24'd0, nib_count}, 32'd1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Key-load priority over a concurrent transfer.
    step(1'b1, 4'h3, 1'b1, 4'h9, 1'b1);
    chk("prio_ready", {31'd0, last_ready}, 32'd0);
    chk("prio_count", {24'd0, nib_count}, 32'd0);
    chk("prio_novalid", {31'd0, pout_valid}, 32'd0);
    step(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    chk("prio_newkey", {28'd0, pout_data}, 32'hA);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Backpressure with no full pass-through.
    step(1'b0, 4'h0, 1'b1, 4'h1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 4'h2, 1'b0);
    step(1'b0, 4'h0, 1'b1, 4'h3, 1'b0);
    chk("bp_full_ready", {31'd0, last_ready}, 32'd0);
    step(1'b0, 4'h0, 1'b1, 4'h3, 1'b1);
    chk("bp_no_passthru", {31'd0, last_ready}, 32'd0);
    step(1'b0, 4'h0, 1'b1, 4'h3, 1'b1);
    chk("bp_third_acc", {31'd0, last_ready}, 32'd1);
    repeat (3) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    // Key rolling (or static key) over three zero ciphertexts.
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 1'b1, 4'h0, 1'b1);
      chk("roll_plain", {28'd0, pout_data}, {28'd0, roll_exp[i]});
    end

    // Counter wrap after 256 accepts.
    step(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    repeat (256) step(1'b0, 4'h0, 1'b1, 4'($urandom), 1'b1);
    chk("wrap_count", {24'd0, nib_count}, 32'd0);

    // Reset drops buffered nibbles.
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1, 4'h7, 1'b0);
    step(1'b0, 4'h0, 1'b1, 4'h8, 1'b0);
    chk("mid_valid", {31'd0, pout_valid}, 32'd1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("midrst_valid", {31'd0, pout_valid}, 32'd0);
    chk("midrst_keyed", {31'd0, keyed}, 32'd0);

    // Random traffic against the model.
    repeat (2000) begin
      step($urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 1) == 1,
           4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
